// File: rtl/reg_demux_1to4_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package reg_demux_1to4_pkg;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned DEF_SIZE = 32;

    typedef logic [SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/reg_demux_1to4_slot.sv
// One output channel: a holding register plus its full flag.
module demux_slot
    import reg_demux_1to4_pkg::*;
#(
    parameter int unsigned size = DEF_SIZE
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [size-1:0] data_i,
    input  logic            ready_i,
    output logic [size-1:0] data_o,
    output logic            valid_o
);

    logic            full;
    logic [size-1:0] data;

    // Load takes priority over drain so a same-cycle refill keeps the slot full.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full <= 1'b0;
            data <= '0;
        end else if (load_i) begin
            full <= 1'b1;
            data <= data_i;
        end else if (full && ready_i) begin
            full <= 1'b0;
        end
    end

    assign data_o  = data;
    assign valid_o = full;

endmodule

// File: rtl/reg_demux_1to4.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready handshake.
module reg_demux_1to4
    import reg_demux_1to4_pkg::*;
#(
    parameter int unsigned size = DEF_SIZE
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic [1:0]      sel_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic [size-1:0] data2_o,
    output logic [size-1:0] data3_o,
    output logic            valid0_o,
    output logic            valid1_o,
    output logic            valid2_o,
    output logic            valid3_o,
    input  logic            ready0_i,
    input  logic            ready1_i,
    input  logic            ready2_i,
    input  logic            ready3_i,
    output logic            busy_o
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] rdy;
    logic [NUM_CH-1:0] load;
    logic [size-1:0]   data_q [NUM_CH];

    assign rdy = {ready3_i, ready2_i, ready1_i, ready0_i};

    // Selected channel can take a word if empty or draining this cycle.
    always_comb begin
        ready_o = !full[sel_i] || rdy[sel_i];
    end

    // Select decode; valid_i gates it so sel_i is ignored when idle.
    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (valid_i && ready_o && (sel_i == ch_sel_t'(k))) begin
                load[k] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_slot #(
            .size (size)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (load[g]),
            .data_i  (data_i),
            .ready_i (rdy[g]),
            .data_o  (data_q[g]),
            .valid_o (full[g])
        );
    end

    assign data0_o  = data_q[0];
    assign data1_o  = data_q[1];
    assign data2_o  = data_q[2];
    assign data3_o  = data_q[3];
    assign valid0_o = full[0];
    assign valid1_o = full[1];
    assign valid2_o = full[2];
    assign valid3_o = full[3];
    assign busy_o   = |full;

endmodule

// File: tb/tb_reg_demux_1to4.sv
// Scoreboard bench for reg_demux_1to4: per-channel expected-word queues.
module tb_reg_demux_1to4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [1:0]  sel_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data0_o, data1_o, data2_o, data3_o;
    logic        valid0_o, valid1_o, valid2_o, valid3_o;
    logic [3:0]  rdy = '0;
    logic        busy_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] dq [4];
    logic [3:0]  vq;
    logic [3:0]  mfull = '0;
    logic [31:0] exp_q [4][$];

    reg_demux_1to4 #(.size(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .sel_i    (sel_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .data1_o  (data1_o),
        .data2_o  (data2_o),
        .data3_o  (data3_o),
        .valid0_o (valid0_o),
        .valid1_o (valid1_o),
        .valid2_o (valid2_o),
        .valid3_o (valid3_o),
        .ready0_i (rdy[0]),
        .ready1_i (rdy[1]),
        .ready2_i (rdy[2]),
        .ready3_i (rdy[3]),
        .busy_o   (busy_o)
    );

    assign dq[0] = data0_o;
    assign dq[1] = data1_o;
    assign dq[2] = data2_o;
    assign dq[3] = data3_o;
    assign vq    = {valid3_o, valid2_o, valid1_o, valid0_o};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: full flags and expected words, updated at each edge.
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            mfull = '0;
            for (int k = 0; k < 4; k++) exp_q[k].delete();
        end else begin
            logic       acc;
            logic [3:0] nxt;
            acc = valid_i && (!mfull[sel_i] || rdy[sel_i]);
            nxt = mfull & ~(mfull & rdy);
            if (acc) begin
                nxt[sel_i] = 1'b1;
                exp_q[sel_i].push_back(data_i);
            end
            mfull = nxt;
        end
    end

    // Monitor: compare handshake outputs and held words mid-cycle.
    always @(negedge clk) begin
        chk("ready_o", 32'(ready_o), 32'(!mfull[sel_i] || rdy[sel_i]));
        chk("valid_vec", 32'(vq), 32'(mfull));
        chk("busy_o", 32'(busy_o), 32'(|mfull));
        for (int k = 0; k < 4; k++) begin
            if (vq[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("unexpected_word%0d", k), dq[k], 32'hxxxx_xxxx);
                end else begin
                    chk($sformatf("data%0d", k), dq[k], exp_q[k][0]);
                    if (rdy[k]) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] s, input logic [31:0] d);
        valid_i = 1'b1;
        sel_i   = s;
        data_i  = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held in reset.
        #12;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(vq), 32'd0);
        chk("rst_data0", data0_o, 32'd0);
        chk("rst_data3", data3_o, 32'd0);
        @(negedge clk);
        #2 rst_i = 1'b1;

        // Single word to channel 2, held because ready2 is low.
        @(posedge clk); #1;
        offer(2'd2, 32'hDEADBEEF);
        edge_step();
        valid_i = 1'b0;
        chk("dir_valid", 32'(vq), 32'b0100);
        chk("dir_data2", data2_o, 32'hDEADBEEF);
        chk("dir_busy", 32'(busy_o), 32'd1);
        rdy = 4'b0100;
        edge_step();
        rdy = '0;
        chk("dir_drained", 32'(vq), 32'd0);

        // Blocked channel 1 vs free channel 3 in the same cycle.
        offer(2'd1, 32'h0000_00A1);
        edge_step();
        offer(2'd1, 32'h0000_00A2);
        #1 chk("blk_ready", 32'(ready_o), 32'd0);
        sel_i  = 2'd3;
        data_i = 32'h0000_00C3;
        #1 chk("free_ready", 32'(ready_o), 32'd1);
        edge_step();
        valid_i = 1'b0;
        chk("blk_data1", data1_o, 32'h0000_00A1);
        chk("free_data3", data3_o, 32'h0000_00C3);
        chk("free_valid", 32'(vq), 32'b1010);
        rdy = 4'hF;
        edge_step();
        rdy = '0;

        // Drain and refill channel 0 in the same cycle: no bubble.
        offer(2'd0, 32'h1);
        edge_step();
        offer(2'd0, 32'h2);
        rdy = 4'b0001;
        #1 chk("refill_ready", 32'(ready_o), 32'd1);
        edge_step();
        valid_i = 1'b0;
        rdy = '0;
        chk("refill_valid0", 32'(valid0_o), 32'd1);
        chk("refill_data0", data0_o, 32'h2);
        rdy = 4'hF;
        edge_step();

        // Back-to-back words to every channel with all consumers ready.
        for (int i = 0; i < 4; i++) begin
            offer(2'(i), 32'h10 + 32'(i));
            edge_step();
        end
        valid_i = 1'b0;
        edge_step();
        chk("b2b_busy", 32'(busy_o), 32'd0);
        chk("b2b_data3", data3_o, 32'h13);

        // Asynchronous reset while channels 0 and 3 hold words.
        rdy = '0;
        offer(2'd0, 32'h55);
        edge_step();
        offer(2'd3, 32'h66);
        edge_step();
        valid_i = 1'b0;
        chk("pre_rst_valid", 32'(vq), 32'b1001);
        @(negedge clk);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_valid", 32'(vq), 32'd0);
        chk("arst_data0", data0_o, 32'd0);
        chk("arst_data3", data3_o, 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        #2 rst_i = 1'b1;
        offer(2'd1, 32'h77);
        edge_step();
        valid_i = 1'b0;
        chk("first_acc_data1", data1_o, 32'h77);
        chk("first_acc_valid", 32'(vq), 32'b0010);

        // Random traffic against the reference queues.
        for (int c = 0; c < 4000; c++) begin
            valid_i = 1'($urandom_range(0, 1));
            sel_i   = 2'($urandom_range(0, 3));
            data_i  = $urandom;
            rdy     = 4'($urandom_range(0, 15));
            edge_step();
        end
        valid_i = 1'b0;
        rdy = 4'hF;
        repeat (4) edge_step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("leftover%0d", k), 32'(exp_q[k].size()), 32'd0);
        end
        chk("final_busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
